// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage between ex_mem and mem_wb.
// Runs one req/ack data-memory transaction per load/store with byte-lane
// enables, store lane replication and load sign/zero extension, and stalls
// the pipeline through pause_o while a transaction is outstanding.
// Optional feature: define MEM_TIMEOUT_EN to abort a transaction whose ack
// does not arrive within TIMEOUT_CYCLES busy cycles (reported on bus_err_o).
module mem_access
`ifdef MEM_TIMEOUT_EN
#(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        inst_valid_i,
    input  logic        reg_wen_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic [31:0] reg_wdata_i,
    input  logic [15:0] pc_i,
    input  logic        mem_en_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_uns_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_sdata_i,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    output logic        pause_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        inst_valid_o,
    output logic        reg_wen_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic [15:0] pc_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] rdata_q;
    logic        discard_q;   // flush seen while the bus was busy
    logic        err_q;       // transaction ended by timeout

    logic        mem_op;
    logic        misaligned;
    logic        issue;
    logic        timeout_hit;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign mem_op     = inst_valid_i & mem_en_i;
    assign misaligned = ((mem_size_i == 2'b01) & mem_addr_i[0]) |
                        (mem_size_i[1] & (mem_addr_i[1:0] != 2'b00));
    assign issue      = (state == IDLE) & mem_op & ~misaligned & ~flush_i;

    // Byte enables and lane-replicated store data for the access being issued.
    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        be_next    = 4'b1111;
        wdata_next = mem_sdata_i;
        case (mem_size_i)
            2'b00: begin
                be_next    = 4'b0001 << mem_addr_i[1:0];
                wdata_next = {4{mem_sdata_i[7:0]}};
            end
            2'b01: begin
                be_next    = 4'b0011 << {mem_addr_i[1], 1'b0};
                wdata_next = {2{mem_sdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Little-endian lane select and extension of the captured read data.
    always_comb begin
        byte_sel = rdata_q[7:0];
        case (mem_addr_i[1:0])
            2'b01:   byte_sel = rdata_q[15:8];
            2'b10:   byte_sel = rdata_q[23:16];
            2'b11:   byte_sel = rdata_q[31:24];
            default: ;
        endcase
        half_sel  = mem_addr_i[1] ? rdata_q[31:16] : rdata_q[15:0];
        load_data = rdata_q;
        case (mem_size_i)
            2'b00:   load_data = {{24{~mem_uns_i & byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{16{~mem_uns_i & half_sel[15]}}, half_sel};
            default: ;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] cnt_q;

    assign timeout_hit = (state == BUSY) & ~dmem_ack_i &
                         (cnt_q == TIMEOUT_CYCLES - 8'd1);

    // Count busy cycles without ack; cleared whenever the FSM is not waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else if ((state == BUSY) && !dmem_ack_i && !timeout_hit) begin
            cnt_q <= cnt_q + 8'd1;
        end else begin
            cnt_q <= 8'd0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Transaction FSM with registered bus outputs.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state        <= IDLE;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= 32'd0;
            dmem_be_o    <= 4'd0;
            dmem_wdata_o <= 32'd0;
            rdata_q      <= 32'd0;
            discard_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= mem_we_i;
                        dmem_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        dmem_be_o    <= be_next;
                        dmem_wdata_o <= wdata_next;
                        discard_q    <= 1'b0;
                        err_q        <= 1'b0;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush_i) begin
                        discard_q <= 1'b1;
                    end
                    if (dmem_ack_i) begin
                        rdata_q    <= dmem_rdata_i;
                        dmem_req_o <= 1'b0;
                        dmem_we_o  <= 1'b0;
                        dmem_be_o  <= 4'd0;
                        state      <= DONE;
                    end else if (timeout_hit) begin
                        dmem_req_o <= 1'b0;
                        dmem_we_o  <= 1'b0;
                        dmem_be_o  <= 4'd0;
                        err_q      <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write-back bundle, stall and status flags.
    always_comb begin
        inst_valid_o = inst_valid_i;
        reg_wen_o    = reg_wen_i;
        reg_waddr_o  = reg_waddr_i;
        reg_wdata_o  = reg_wdata_i;
        pc_o         = pc_i;
        pause_o      = 1'b0;
        misalign_o   = 1'b0;
        bus_err_o    = 1'b0;
        if (rst) begin
            inst_valid_o = 1'b0;
            reg_wen_o    = 1'b0;
            reg_waddr_o  = 5'd0;
            reg_wdata_o  = 32'd0;
            pc_o         = 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op && misaligned) begin
                        reg_wen_o  = 1'b0;
                        misalign_o = 1'b1;
                    end else if (mem_op) begin
                        inst_valid_o = 1'b0;
                        reg_wen_o    = 1'b0;
                        pause_o      = ~flush_i;
                    end
                end
                BUSY: begin
                    inst_valid_o = 1'b0;
                    reg_wen_o    = 1'b0;
                    pause_o      = 1'b1;
                end
                DONE: begin
                    if (!mem_we_i) begin
                        reg_wdata_o = load_data;
                    end
                    if (err_q) begin
                        bus_err_o    = 1'b1;
                        reg_wen_o    = 1'b0;
                        inst_valid_o = 1'b1;
                    end
                    if (discard_q) begin
                        inst_valid_o = 1'b0;
                        reg_wen_o    = 1'b0;
                    end
                end
                default: ;
            endcase
            if (flush_i && (state != BUSY)) begin
                inst_valid_o = 1'b0;
                reg_wen_o    = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Testbench for mem_access: directed scenarios plus randomized loads, stores
// and ALU ops checked against a transaction-level reference model.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i, inst_valid_i, reg_wen_i;
    logic [4:0]  reg_waddr_i;
    logic [31:0] reg_wdata_i;
    logic [15:0] pc_i;
    logic        mem_en_i, mem_we_i, mem_uns_i;
    logic [1:0]  mem_size_i;
    logic [31:0] mem_addr_i, mem_sdata_i, dmem_rdata_i;
    logic        dmem_ack_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        pause_o, misalign_o, bus_err_o;
    logic        inst_valid_o, reg_wen_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic [15:0] pc_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

`ifdef MEM_TIMEOUT_EN
    mem_access #(.TIMEOUT_CYCLES(8'd4)) dut (
`else
    mem_access dut (
`endif
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .inst_valid_i(inst_valid_i), .reg_wen_i(reg_wen_i),
        .reg_waddr_i(reg_waddr_i), .reg_wdata_i(reg_wdata_i), .pc_i(pc_i),
        .mem_en_i(mem_en_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
        .mem_uns_i(mem_uns_i), .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
        .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .pause_o(pause_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o),
        .inst_valid_o(inst_valid_o), .reg_wen_o(reg_wen_o),
        .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o), .pc_o(pc_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---- reference model: access rules expressed as plain arithmetic ----
    function automatic int unsigned size_bytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [31:0] a);
        return (a % size_bytes(size)) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [31:0] a);
        int unsigned n;
        int unsigned off;
        n   = size_bytes(size);
        off = a % 4;
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size_bytes(size))
            1:       return (d & 32'hFF) * 32'h0101_0101;
            2:       return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] a, input logic [31:0] r);
        int unsigned n;
        logic [31:0] mask;
        logic [31:0] v;
        n = size_bytes(size);
        if (n == 4) return r;
        mask = (32'd1 << (n * 8)) - 32'd1;
        v    = (r >> ((a % 4) * 8)) & mask;
        if (!uns && v[n*8-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic idle_inputs();
        flush_i = 0; inst_valid_i = 0; reg_wen_i = 0; reg_waddr_i = 0;
        reg_wdata_i = 0; pc_i = 0; mem_en_i = 0; mem_we_i = 0; mem_size_i = 0;
        mem_uns_i = 0; mem_addr_i = 0; mem_sdata_i = 0; dmem_rdata_i = 0;
        dmem_ack_i = 0;
    endtask

    // Apply one instruction (called just after a posedge) and follow it to retirement.
    // ack_delay: busy cycles without ack before the ack cycle; flush_at: busy
    // cycle index that carries a flush pulse (-1 for none).
    task automatic run_op(input logic valid, input logic mem_en, input logic we,
                          input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] alu, input logic [4:0] waddr,
                          input logic wen, input logic [15:0] pc,
                          input int ack_delay, input int flush_at);
        logic [31:0] rdata;
        inst_valid_i = valid; mem_en_i = mem_en; mem_we_i = we; mem_size_i = size;
        mem_uns_i = uns; mem_addr_i = addr; mem_sdata_i = sdata; reg_wdata_i = alu;
        reg_waddr_i = waddr; reg_wen_i = wen; pc_i = pc; flush_i = 0;
        rdata = $urandom;
        @(negedge clk);
        if (!(valid && mem_en)) begin
            check("alu_valid", inst_valid_o, valid);
            check("alu_wen", reg_wen_o, wen);
            check("alu_waddr", reg_waddr_o, waddr);
            check("alu_wdata", reg_wdata_o, alu);
            check("alu_pc", pc_o, pc);
            check("alu_pause", pause_o, 0);
            check("alu_req", dmem_req_o, 0);
            dmem_ack_i = 1'($urandom % 2);      // stray ack must be ignored
            @(posedge clk); #1;
            dmem_ack_i = 0;
            return;
        end
        if (is_misaligned(size, addr)) begin
            check("mis_flag", misalign_o, 1);
            check("mis_wen", reg_wen_o, 0);
            check("mis_valid", inst_valid_o, 1);
            check("mis_pause", pause_o, 0);
            check("mis_req", dmem_req_o, 0);
            @(posedge clk); #1;
            @(negedge clk);
            check("mis_noreq", dmem_req_o, 0);
            return;
        end
        check("issue_pause", pause_o, 1);
        check("issue_valid", inst_valid_o, 0);
        check("issue_mis", misalign_o, 0);
        @(posedge clk); #1;
        for (int c = 0; c <= ack_delay; c++) begin
            flush_i      = (c == flush_at);
            dmem_ack_i   = (c == ack_delay);
            dmem_rdata_i = (c == ack_delay) ? rdata : $urandom;
            @(negedge clk);
            check("busy_req", dmem_req_o, 1);
            check("busy_we", dmem_we_o, we);
            check("busy_addr", dmem_addr_o, addr & 32'hFFFF_FFFC);
            check("busy_be", dmem_be_o, ref_be(size, addr));
            check("busy_wdata", dmem_wdata_o, ref_wdata(size, sdata));
            check("busy_pause", pause_o, 1);
            check("busy_valid", inst_valid_o, 0);
            @(posedge clk); #1;
        end
        flush_i = 0; dmem_ack_i = 0; dmem_rdata_i = $urandom;
        @(negedge clk);
        check("done_pause", pause_o, 0);
        check("done_req", dmem_req_o, 0);
        check("done_be", dmem_be_o, 0);
        check("done_err", bus_err_o, 0);
        check("done_valid", inst_valid_o, (flush_at >= 0) ? 0 : 1);
        check("done_wen", reg_wen_o, (flush_at >= 0) ? 0 : wen);
        check("done_waddr", reg_waddr_o, waddr);
        check("done_wdata", reg_wdata_o, we ? alu : ref_load(size, uns, addr, rdata));
        @(posedge clk); #1;
    endtask

    initial begin
        idle_inputs();
        // Reset with a busy-looking input bundle: every output must read zero.
        rst = 1; inst_valid_i = 1; reg_wen_i = 1; reg_waddr_i = 5'd7;
        reg_wdata_i = 32'hDEAD; pc_i = 16'h55; mem_en_i = 1; mem_size_i = 2'd2;
        mem_addr_i = 32'h1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_valid", inst_valid_o, 0);
        check("rst_wen", reg_wen_o, 0);
        check("rst_waddr", reg_waddr_o, 0);
        check("rst_wdata", reg_wdata_o, 0);
        check("rst_pc", pc_o, 0);
        check("rst_pause", pause_o, 0);
        check("rst_mis", misalign_o, 0);
        check("rst_req", dmem_req_o, 0);
        check("rst_addr", dmem_addr_o, 0);
        check("rst_be", dmem_be_o, 0);
        check("rst_wdata_bus", dmem_wdata_o, 0);
        @(posedge clk); #1;
        rst = 0; idle_inputs();

        // Directed cases.
        run_op(1, 0, 0, 2'd2, 0, 32'h0, 32'h0, 32'h1234, 5'd5, 1, 16'h10, 0, -1);
        run_op(1, 1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h0, 5'd6, 1, 16'h14, 1, -1);
        run_op(1, 1, 1, 2'd1, 0, 32'h202, 32'hABCD, 32'h202, 5'd0, 0, 16'h18, 0, -1);
        run_op(1, 1, 0, 2'd2, 0, 32'h301, 32'h0, 32'h0, 5'd7, 1, 16'h1C, 0, -1);
        run_op(1, 1, 0, 2'd2, 0, 32'h304, 32'h0, 32'h0, 5'd8, 1, 16'h20, 2, 0);
        run_op(1, 1, 0, 2'd1, 1, 32'h306, 32'h0, 32'h0, 5'd9, 1, 16'h24, 0, -1);

        // Synchronous reset while busy, then a late ack that must be ignored.
        inst_valid_i = 1; mem_en_i = 1; mem_size_i = 2'd2; mem_addr_i = 32'h400;
        reg_wen_i = 1;
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        check("rstbusy_pause", pause_o, 0);
        check("rstbusy_valid", inst_valid_o, 0);
        @(posedge clk); #1;
        rst = 0; idle_inputs(); dmem_ack_i = 1; dmem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        check("rstbusy_req", dmem_req_o, 0);
        check("rstbusy_addr", dmem_addr_o, 0);
        @(posedge clk); #1;
        dmem_ack_i = 0;
        @(negedge clk);
        check("lateack_req", dmem_req_o, 0);
        check("lateack_pause", pause_o, 0);
        @(posedge clk); #1;

`ifdef MEM_TIMEOUT_EN
        // No ack: the request is abandoned after four busy cycles.
        inst_valid_i = 1; mem_en_i = 1; mem_we_i = 0; mem_size_i = 2'd2;
        mem_addr_i = 32'h500; reg_wen_i = 1;
        @(posedge clk); #1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("to_req", dmem_req_o, 1);
            check("to_pause", pause_o, 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("to_dropped", dmem_req_o, 0);
        check("to_err", bus_err_o, 1);
        check("to_wen", reg_wen_o, 0);
        check("to_valid", inst_valid_o, 1);
        check("to_pause_done", pause_o, 0);
        @(posedge clk); #1;
        idle_inputs();
`endif

        // Randomized instruction stream.
        for (int i = 0; i < 200; i++) begin
            logic        r_mem;
            logic        r_we;
            logic [31:0] r_addr;
            int          r_delay;
            int          r_flush;
            r_mem   = ($urandom % 3) != 0;
            r_we    = 1'($urandom % 2);
            r_addr  = $urandom;
            r_delay = int'($urandom_range(0, 3));
            r_flush = (($urandom % 5) == 0) ? int'($urandom_range(0, r_delay)) : -1;
            run_op(($urandom % 8) != 0, r_mem, r_we, 2'($urandom % 4), 1'($urandom % 2),
                   r_addr, $urandom, $urandom, 5'($urandom), r_mem ? !r_we : 1'($urandom % 2),
                   16'($urandom), r_delay, r_flush);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog: the stream is bounded, so this only trips on a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
